// File: rtl/softmax_in_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_in_buffer_if
//  Description : Bundle of the load stream, engine control and the three
//                read ports of the softmax input buffer.
//                slave  - buffer side, master - producer/engine side.
//                Optional elem_count member exists when SOFTMAX_BUF_CNT_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface softmax_in_buffer_if #(
    parameter int DATAWIDTH = 16,
    parameter int NUM       = 4,
    parameter int ADDRSIZE  = 8
);
    // Load stream and control
    logic                      load_start;
    logic [ADDRSIZE-1:0]       base_addr;
    logic [DATAWIDTH-1:0]      in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_ready;
    // Engine handshake
    logic                      sm_start;
    logic [ADDRSIZE-1:0]       sm_start_addr;
    logic [ADDRSIZE-1:0]       sm_end_addr;
    logic                      sm_release;
    logic                      busy;
    logic                      full;
    // Read ports
    logic [ADDRSIZE-1:0]       addr;
    logic [ADDRSIZE-1:0]       sub0_inp_addr;
    logic [ADDRSIZE-1:0]       sub1_inp_addr;
    logic [DATAWIDTH*NUM-1:0]  inp;
    logic [DATAWIDTH*NUM-1:0]  sub0_inp;
    logic [DATAWIDTH*NUM-1:0]  sub1_inp;
`ifdef SOFTMAX_BUF_CNT_EN
    logic [ADDRSIZE+$clog2(NUM)-1:0] elem_count;
`endif

    modport slave (
`ifdef SOFTMAX_BUF_CNT_EN
        output elem_count,
`endif
        input  load_start, base_addr, in_data, in_valid, in_last,
        input  sm_release, addr, sub0_inp_addr, sub1_inp_addr,
        output in_ready, sm_start, sm_start_addr, sm_end_addr,
        output busy, full, inp, sub0_inp, sub1_inp
    );

    modport master (
`ifdef SOFTMAX_BUF_CNT_EN
        input  elem_count,
`endif
        output load_start, base_addr, in_data, in_valid, in_last,
        output sm_release, addr, sub0_inp_addr, sub1_inp_addr,
        input  in_ready, sm_start, sm_start_addr, sm_end_addr,
        input  busy, full, inp, sub0_inp, sub1_inp
    );
endinterface
`default_nettype wire

// File: rtl/softmax_in_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_in_buffer
//  Description : Input buffer for the softmax engine. Packs NUM streamed
//                elements per memory word, reports the start/end word of the
//                loaded vector, pulses sm_start, and serves three registered
//                read ports (1-cycle latency, old data on read-during-write).
//  Ports       : clk, reset (sync, active-high), bus (softmax_in_buffer_if
//                slave: load stream, engine control, read ports).
//  Option      : SOFTMAX_BUF_CNT_EN adds elem_count (accepted elements of
//                the current load, pad lanes excluded).
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_in_buffer #(
    parameter int                   DATAWIDTH = 16,
    parameter int                   NUM       = 4,
    parameter int                   ADDRSIZE  = 8,
    parameter logic [DATAWIDTH-1:0] PAD_VALUE = 16'h0000
) (
    input  wire logic            clk,
    input  wire logic            reset,
    softmax_in_buffer_if.slave   bus
);
    localparam int c_word_w = DATAWIDTH * NUM;
    localparam int c_lane_w = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [c_lane_w-1:0] c_lane_last = c_lane_w'(NUM - 1);
    localparam logic [ADDRSIZE-1:0] c_addr_last = '1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_start = 2'd2;
    localparam logic [1:0] c_run   = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic                   w_in_ready;
    logic                   w_sm_start;
    logic                   w_busy;

    logic [c_lane_w-1:0]    r_lane_cnt;
    logic [ADDRSIZE-1:0]    r_wr_ptr;
    logic [c_word_w-1:0]    r_pack;
    logic [ADDRSIZE-1:0]    r_start_addr;
    logic [ADDRSIZE-1:0]    r_end_addr;
    logic                   r_full;
    logic [c_word_w-1:0]    r_mem [0:(2**ADDRSIZE)-1];
    logic [c_word_w-1:0]    r_inp;
    logic [c_word_w-1:0]    r_sub0_inp;
    logic [c_word_w-1:0]    r_sub1_inp;

    logic                   w_load_go;
    logic                   w_accept;
    logic                   w_commit;
    logic                   w_done;
    logic [c_word_w-1:0]    w_word;

    assign w_load_go = (r_state == c_idle) & bus.load_start;
    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_commit  = w_accept & ((r_lane_cnt == c_lane_last) | bus.in_last);
    // A commit ends the load either on in_last or on reaching the top word.
    assign w_done    = w_commit & (bus.in_last | (r_wr_ptr == c_addr_last));

    // Word as it would be committed now: earlier lanes from the pack
    // register, current lane from the input, later lanes padded.
    genvar k;
    generate
        for (k = 0; k < NUM; k++) begin : g_lane
            localparam logic [c_lane_w-1:0] c_k = c_lane_w'(k);
            assign w_word[k*DATAWIDTH +: DATAWIDTH] =
                (c_k < r_lane_cnt)  ? r_pack[k*DATAWIDTH +: DATAWIDTH] :
                (c_k == r_lane_cnt) ? bus.in_data : PAD_VALUE;
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_idle;
        else       r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (bus.load_start) w_next_state = c_load;
            c_load:  if (w_done)         w_next_state = c_start;
            c_start:                     w_next_state = c_run;
            c_run:   if (bus.sm_release) w_next_state = c_idle;
            default:                     w_next_state = c_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready = 1'b0;
        w_sm_start = 1'b0;
        w_busy     = 1'b1;
        case (r_state)
            c_idle:  w_busy     = 1'b0;
            c_load:  w_in_ready = 1'b1;
            c_start: w_sm_start = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Packing / address tracking ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_pack       <= '0;
            r_start_addr <= '0;
            r_end_addr   <= '0;
            r_full       <= 1'b0;
        end else if (w_load_go) begin
            r_lane_cnt   <= '0;
            r_wr_ptr     <= bus.base_addr;
            r_pack       <= '0;
            r_start_addr <= bus.base_addr;
            r_full       <= 1'b0;
        end else if (w_accept) begin
            if (w_commit) begin
                r_lane_cnt <= '0;
                r_pack     <= '0;
                // Pointer saturates at the top word instead of wrapping.
                if (r_wr_ptr != c_addr_last)
                    r_wr_ptr <= r_wr_ptr + ADDRSIZE'(1);
                if (bus.in_last) begin
                    // Exact fit into the top word is not a truncation.
                    r_end_addr <= r_wr_ptr;
                end else if (r_wr_ptr == c_addr_last) begin
                    r_end_addr <= c_addr_last;
                    r_full     <= 1'b1;
                end
            end else begin
                r_lane_cnt <= r_lane_cnt + c_lane_w'(1);
                r_pack     <= w_word;
            end
        end
    end

    // ---------------- Memory write ----------------
    always_ff @(posedge clk) begin
        if (!reset && w_commit)
            r_mem[r_wr_ptr] <= w_word;
    end

    // ---------------- Registered read ports ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inp      <= '0;
            r_sub0_inp <= '0;
            r_sub1_inp <= '0;
        end else begin
            r_inp      <= r_mem[bus.addr];
            r_sub0_inp <= r_mem[bus.sub0_inp_addr];
            r_sub1_inp <= r_mem[bus.sub1_inp_addr];
        end
    end

`ifdef SOFTMAX_BUF_CNT_EN
    localparam int c_cnt_w = ADDRSIZE + $clog2(NUM);
    logic [c_cnt_w-1:0] r_elem_count;

    always_ff @(posedge clk) begin
        if (reset || w_load_go) r_elem_count <= '0;
        else if (w_accept)      r_elem_count <= r_elem_count + c_cnt_w'(1);
    end

    assign bus.elem_count = r_elem_count;
`endif

    assign bus.in_ready      = w_in_ready;
    assign bus.sm_start      = w_sm_start;
    assign bus.busy          = w_busy;
    assign bus.full          = r_full;
    assign bus.sm_start_addr = r_start_addr;
    assign bus.sm_end_addr   = r_end_addr;
    assign bus.inp           = r_inp;
    assign bus.sub0_inp      = r_sub0_inp;
    assign bus.sub1_inp      = r_sub1_inp;

endmodule
`default_nettype wire

// File: tb/tb_softmax_in_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_in_buffer
//  Description : Directed self-checking bench for softmax_in_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_in_buffer;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    softmax_in_buffer_if #(.DATAWIDTH(16), .NUM(4), .ADDRSIZE(8)) bus ();

    softmax_in_buffer #(
        .DATAWIDTH(16), .NUM(4), .ADDRSIZE(8), .PAD_VALUE(16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last, input int gap);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_load(input logic [7:0] base);
        bus.base_addr  = base;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic release_buf();
        bus.sm_release = 1'b1;
        tick();
        bus.sm_release = 1'b0;
    endtask

    task automatic read3(input logic [7:0] a, input logic [7:0] s0, input logic [7:0] s1);
        bus.addr          = a;
        bus.sub0_inp_addr = s0;
        bus.sub1_inp_addr = s1;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.load_start    = 1'b0;
        bus.base_addr     = '0;
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        bus.in_last       = 1'b0;
        bus.sm_release    = 1'b0;
        bus.addr          = '0;
        bus.sub0_inp_addr = '0;
        bus.sub1_inp_addr = '0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_in_ready",   {63'd0, bus.in_ready}, 64'd0);
        chk("rst_busy",       {63'd0, bus.busy},     64'd0);
        chk("rst_sm_start",   {63'd0, bus.sm_start}, 64'd0);
        chk("rst_full",       {63'd0, bus.full},     64'd0);
        chk("rst_start_addr", {56'd0, bus.sm_start_addr}, 64'd0);
        chk("rst_end_addr",   {56'd0, bus.sm_end_addr},   64'd0);
        chk("rst_inp",        bus.inp,      64'd0);
        chk("rst_sub0",       bus.sub0_inp, 64'd0);
        chk("rst_sub1",       bus.sub1_inp, 64'd0);
        reset = 1'b0;
        tick();

        // ---- scenario 1: 8 elements at 0x10 ----
        start_load(8'h10);
        chk("s1_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("s1_busy",     {63'd0, bus.busy},     64'd1);
        for (int i = 1; i <= 7; i++) send(16'(i), 1'b0, 0);
        chk("s1_no_early_start", {63'd0, bus.sm_start}, 64'd0);
        send(16'd8, 1'b1, 0);
        chk("s1_sm_start",   {63'd0, bus.sm_start}, 64'd1);
        chk("s1_ready_off",  {63'd0, bus.in_ready}, 64'd0);
        chk("s1_start_addr", {56'd0, bus.sm_start_addr}, 64'h10);
        chk("s1_end_addr",   {56'd0, bus.sm_end_addr},   64'h11);
        chk("s1_full",       {63'd0, bus.full},     64'd0);
        tick();
        chk("s1_start_1cyc", {63'd0, bus.sm_start}, 64'd0);
        chk("s1_busy_run",   {63'd0, bus.busy},     64'd1);
        read3(8'h10, 8'h11, 8'h10);
        chk("s1_inp",  bus.inp,      64'h0004_0003_0002_0001);
        chk("s1_sub0", bus.sub0_inp, 64'h0008_0007_0006_0005);
        chk("s1_sub1", bus.sub1_inp, 64'h0004_0003_0002_0001);
        // load_start during RUN must be ignored
        start_load(8'h55);
        chk("s1_ign_busy",  {63'd0, bus.busy},     64'd1);
        chk("s1_ign_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("s1_ign_start_addr", {56'd0, bus.sm_start_addr}, 64'h10);
        tick();
        chk("s1_ign_no_start", {63'd0, bus.sm_start}, 64'd0);
        release_buf();
        chk("s1_release_busy", {63'd0, bus.busy}, 64'd0);

        // ---- scenario 2: 6 elements at 0 with gaps, padded final word ----
        start_load(8'h00);
        send(16'd1, 1'b0, 1);
        send(16'd2, 1'b0, 3);
        send(16'd3, 1'b0, 2);
        send(16'd4, 1'b0, 1);
        send(16'd5, 1'b0, 3);
        chk("s2_gap_no_start", {63'd0, bus.sm_start}, 64'd0);
        send(16'd6, 1'b1, 0);
        chk("s2_sm_start", {63'd0, bus.sm_start},     64'd1);
        chk("s2_end_addr", {56'd0, bus.sm_end_addr},  64'h01);
`ifdef SOFTMAX_BUF_CNT_EN
        chk("s2_elem_count", {54'd0, bus.elem_count}, 64'd6);
`endif
        read3(8'h01, 8'h00, 8'h01);
        chk("s2_inp_pad", bus.inp,      64'h0000_0000_0006_0005);
        chk("s2_sub0",    bus.sub0_inp, 64'h0004_0003_0002_0001);
        release_buf();

        // ---- scenario 3: truncation at the top of memory ----
        start_load(8'hFE);
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0, 0);
        chk("s3_ready_off", {63'd0, bus.in_ready},    64'd0);
        chk("s3_sm_start",  {63'd0, bus.sm_start},    64'd1);
        chk("s3_full",      {63'd0, bus.full},        64'd1);
        chk("s3_end_addr",  {56'd0, bus.sm_end_addr}, 64'hFF);
        for (int i = 9; i <= 12; i++) begin
            send(16'(i), 1'b0, 0);
            chk("s3_no_accept", {63'd0, bus.in_ready}, 64'd0);
        end
`ifdef SOFTMAX_BUF_CNT_EN
        chk("s3_elem_count", {54'd0, bus.elem_count}, 64'd8);
`endif
        read3(8'hFE, 8'hFF, 8'hFF);
        chk("s3_inp",  bus.inp,      64'h0004_0003_0002_0001);
        chk("s3_sub0", bus.sub0_inp, 64'h0008_0007_0006_0005);
        chk("s3_end_stable", {56'd0, bus.sm_end_addr}, 64'hFF);
        release_buf();

        // ---- scenario 4: reset mid-load ----
        start_load(8'h20);
        send(16'd1, 1'b0, 0);
        send(16'd2, 1'b0, 0);
        send(16'd3, 1'b0, 0);
        reset = 1'b1;
        tick();
        chk("s4_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("s4_busy",  {63'd0, bus.busy},     64'd0);
        chk("s4_start", {63'd0, bus.sm_start}, 64'd0);
        reset = 1'b0;
        tick();
        chk("s4_no_start", {63'd0, bus.sm_start}, 64'd0);
        start_load(8'h30);
        send(16'd9,  1'b0, 0);
        send(16'd10, 1'b0, 0);
        send(16'd11, 1'b0, 0);
        send(16'd12, 1'b1, 0);
        chk("s4_sm_start", {63'd0, bus.sm_start},      64'd1);
        chk("s4_start_addr", {56'd0, bus.sm_start_addr}, 64'h30);
        chk("s4_end_addr", {56'd0, bus.sm_end_addr},   64'h30);
        read3(8'h30, 8'h30, 8'h30);
        chk("s4_inp", bus.inp, 64'h000C_000B_000A_0009);
        release_buf();

        // ---- scenario 5: in_last exactly at the top word ----
        start_load(8'hFF);
        send(16'h21, 1'b0, 0);
        send(16'h22, 1'b0, 0);
        send(16'h23, 1'b0, 0);
        send(16'h24, 1'b1, 0);
        chk("s5_sm_start", {63'd0, bus.sm_start},    64'd1);
        chk("s5_full",     {63'd0, bus.full},        64'd0);
        chk("s5_end_addr", {56'd0, bus.sm_end_addr}, 64'hFF);
        read3(8'hFF, 8'hFE, 8'hFF);
        chk("s5_inp",  bus.inp,      64'h0024_0023_0022_0021);
        chk("s5_sub0", bus.sub0_inp, 64'h0004_0003_0002_0001);
        release_buf();
        chk("s5_release_busy", {63'd0, bus.busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
